// File: rtl/seg7_scan_decoder.sv
// Reader side of a multiplexed 7-segment display: synchronises the anode and segment pins,
// decodes each digit's pattern back to a hex nibble, and publishes a frame once it has repeated.
module seg7_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int SETTLE = 4,
    parameter int STABLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an_n,
    input  logic [0:6]            seg_n,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid,
    output logic                  anode_fault
);

    localparam int SELW = $clog2(DIGITS);
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int MW   = $clog2(STABLE + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    state_t               state, state_nx;
    logic [SELW-1:0]      sel, sel_nx, idx;
    logic [CNTW-1:0]      cnt, cnt_nx;
    logic                 sample;

    logic [DIGITS-1:0]    an_s1, an_s2, low;
    logic [0:6]           seg_s1, seg_s2;
    logic                 none_low, one_low, multi_low, multi_d;

    logic [3:0]           dec_nib;
    logic                 dec_err;

    logic [4*DIGITS-1:0]  stg_nib, prev_nib;
    logic [DIGITS-1:0]    stg_err, prev_err, mask;
    logic [MW-1:0]        match, match_nx;
    logic                 same;

    // Synchronisers reset to the idle pin level so a reset never looks like a multi-anode fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_s1  <= '1;
            an_s2  <= '1;
            seg_s1 <= '1;
            seg_s2 <= '1;
        end else begin
            an_s1  <= an_n;
            an_s2  <= an_s1;
            seg_s1 <= seg_n;
            seg_s2 <= seg_s1;
        end
    end

    always_comb begin
        low       = ~an_s2;
        none_low  = (low == '0);
        one_low   = !none_low && ((low & (low - DIGITS'(1))) == '0);
        multi_low = !none_low && !one_low;
        idx       = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (low[i]) idx = SELW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        cnt_nx   = cnt;
        sample   = 1'b0;
        if (!one_low) begin
            state_nx = ST_IDLE;
        end else if (state == ST_IDLE || idx != sel) begin
            state_nx = ST_SETTLE;
            sel_nx   = idx;
            cnt_nx   = '0;
        end else if (state == ST_SETTLE) begin
            if (cnt == CNTW'(SETTLE - 1)) begin
                sample   = 1'b1;
                state_nx = ST_HOLD;
            end else begin
                cnt_nx = cnt + CNTW'(1);
            end
        end
    end

    always_comb begin
        dec_nib = 4'h0;
        dec_err = 1'b0;
        case (seg_s2)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            default:    dec_err = 1'b1;
        endcase
    end

    always_comb begin
        same = (stg_nib == prev_nib) && (stg_err == prev_err);
        if (!same)
            match_nx = MW'(1);
        else if (match == MW'(STABLE))
            match_nx = match;
        else
            match_nx = match + MW'(1);
    end

    // A sample arriving while the frame is complete is applied first; evaluation waits a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_nib     <= '0;
            stg_err     <= '0;
            prev_nib    <= '0;
            prev_err    <= '0;
            mask        <= '0;
            match       <= '0;
            multi_d     <= 1'b0;
            digits      <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            anode_fault <= 1'b0;
        end else begin
            multi_d     <= multi_low;
            anode_fault <= multi_low && !multi_d;
            frame_valid <= 1'b0;
            if (sample) begin
                stg_nib[{sel, 2'b00} +: 4] <= dec_nib;
                stg_err[sel]               <= dec_err;
                mask[sel]                  <= 1'b1;
            end else if (mask == '1) begin
                mask     <= '0;
                prev_nib <= stg_nib;
                prev_err <= stg_err;
                match    <= match_nx;
                if (match_nx == MW'(STABLE)) begin
                    digits      <= stg_nib;
                    digit_err   <= stg_err;
                    frame_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: an event-level frame model predicts every publish and
// fault pulse; a negedge monitor compares the outputs against it each cycle.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int SETTLE = 4;
    localparam int STABLE = 2;
    localparam int DWELL  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an_n = '1;
    logic [0:6]  seg_n = '1;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        anode_fault;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE), .STABLE(STABLE)) dut (
        .clk(clk), .rst(rst), .an_n(an_n), .seg_n(seg_n),
        .digits(digits), .digit_err(digit_err),
        .frame_valid(frame_valid), .anode_fault(anode_fault)
    );

    logic [0:6] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int errors = 0;
    int checks = 0;

    // Frame model: what each digit slot holds, which slots have been read, and the last frame.
    logic [3:0]  m_nib  [DIGITS];
    logic        m_err  [DIGITS];
    logic        m_seen [DIGITS];
    logic [15:0] p_nib;
    logic [3:0]  p_err;
    int          m_match;
    logic [19:0] expq [$];
    int          exp_flt;
    logic [3:0]  last_an;
    logic [15:0] pub_d;
    logic [3:0]  pub_e;
    int          fv_cnt;
    int          flt_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < DIGITS; d++) begin
            m_nib[d]  = '0;
            m_err[d]  = 1'b0;
            m_seen[d] = 1'b0;
        end
        p_nib   = '0;
        p_err   = '0;
        m_match = 0;
        expq.delete();
        pub_d   = '0;
        pub_e   = '0;
    endtask

    task automatic model_sample(input int d, input logic [0:6] s);
        logic [3:0]  nib;
        logic        err;
        logic [15:0] cn;
        logic [3:0]  ce;
        bit          full;
        nib = 4'h0;
        err = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (pat[k] === s) begin
                nib = 4'(k);
                err = 1'b0;
            end
        end
        m_nib[d]  = nib;
        m_err[d]  = err;
        m_seen[d] = 1'b1;
        full = 1'b1;
        for (int i = 0; i < DIGITS; i++) full &= m_seen[i];
        if (full) begin
            for (int i = 0; i < DIGITS; i++) begin
                cn[4*i +: 4] = m_nib[i];
                ce[i]        = m_err[i];
                m_seen[i]    = 1'b0;
            end
            if (cn == p_nib && ce == p_err) m_match = (m_match < STABLE) ? m_match + 1 : STABLE;
            else                            m_match = 1;
            p_nib = cn;
            p_err = ce;
            if (m_match == STABLE) expq.push_back({ce, cn});
        end
    endtask

    task automatic drive_an(input logic [3:0] a, input int cyc);
        if ($countones(~a) > 1 && $countones(~last_an) <= 1) exp_flt++;
        an_n    = a;
        last_an = a;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic show(input int d, input logic [0:6] s, input int cyc);
        logic [3:0] one;
        one   = 4'b0001 << d;
        seg_n = s;
        if (cyc >= SETTLE + 1) model_sample(d, s);
        drive_an(~one, cyc);
    endtask

    task automatic frame4(input logic [15:0] v, input logic [3:0] blank);
        for (int d = 0; d < DIGITS; d++)
            show(d, blank[d] ? 7'b1111111 : pat[v[4*d +: 4]], DWELL);
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        an_n    = '1;
        seg_n   = '1;
        last_an = '1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_digit_err", 32'(digit_err), 32'h0);
        chk("reset_frame_valid", 32'(frame_valid), 32'h0);
        chk("reset_anode_fault", 32'(anode_fault), 32'h0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (anode_fault) flt_cnt++;
            if (frame_valid) begin
                fv_cnt++;
                if (expq.size() == 0) begin
                    chk("unexpected_frame_valid", 32'(frame_valid), 32'h0);
                end else begin
                    {pub_e, pub_d} = expq.pop_front();
                end
            end
            chk("digits", 32'(digits), 32'(pub_d));
            chk("digit_err", 32'(digit_err), 32'(pub_e));
        end
    end

    int fv0, flt0;

    initial begin
        exp_flt = 0;
        fv_cnt  = 0;
        flt_cnt = 0;
        last_an = '1;
        model_clear();
        reset_dut();
        drive_an(4'hF, 5);

        fv0 = fv_cnt;
        frame4(16'hF3A1, 4'b0000);
        frame4(16'hF3A1, 4'b0000);
        chk("scan_fv_after_2", 32'(fv_cnt - fv0), 32'd1);
        chk("scan_digits", 32'(digits), 32'hF3A1);
        chk("scan_err", 32'(digit_err), 32'h0);
        frame4(16'hF3A1, 4'b0000);
        chk("scan_fv_after_3", 32'(fv_cnt - fv0), 32'd2);

        fv0 = fv_cnt;
        frame4(16'hF3A1, 4'b0100);
        frame4(16'hF3A1, 4'b0100);
        chk("blank_fv", 32'(fv_cnt - fv0), 32'd1);
        chk("blank_err", 32'(digit_err), 32'b0100);
        chk("blank_nibble", 32'(digits[11:8]), 32'h0);
        chk("blank_digits", 32'(digits), 32'hF0A1);

        show(0, pat[1], DWELL);
        show(1, pat[2], DWELL);
        reset_dut();
        fv0 = fv_cnt;
        show(2, pat[3], DWELL);
        show(3, pat[4], DWELL);
        show(0, pat[1], DWELL);
        show(1, pat[2], DWELL);
        chk("rst_fv_first_frame", 32'(fv_cnt - fv0), 32'd0);
        show(2, pat[3], DWELL);
        show(3, pat[4], DWELL);
        show(0, pat[1], DWELL);
        show(1, pat[2], DWELL);
        chk("rst_fv_second_frame", 32'(fv_cnt - fv0), 32'd1);
        chk("rst_digits", 32'(digits), 32'h4321);

        fv0 = fv_cnt;
        for (int r = 0; r < 2; r++) begin
            show(0, pat[5], DWELL);
            show(1, pat[6], DWELL);
            show(2, pat[7], DWELL);
            show(3, pat[8], 3);
            drive_an(4'hF, 10);
        end
        chk("short_hold_fv", 32'(fv_cnt - fv0), 32'd0);
        show(0, pat[5], DWELL);
        show(1, pat[6], DWELL);
        show(2, pat[7], DWELL);
        show(3, pat[8], 2 + SETTLE);
        drive_an(4'hF, 10);
        chk("min_hold_fv", 32'(fv_cnt - fv0), 32'd0);
        frame4(16'h8765, 4'b0000);
        chk("min_hold_publish", 32'(fv_cnt - fv0), 32'd1);
        chk("min_hold_digits", 32'(digits), 32'h8765);

        fv0  = fv_cnt;
        flt0 = flt_cnt;
        show(0, pat[1], DWELL);
        show(1, pat[10], DWELL);
        drive_an(4'b1100, 5);
        chk("fault_pulses", 32'(flt_cnt - flt0), 32'd1);
        show(2, pat[3], DWELL);
        show(3, pat[15], DWELL);
        frame4(16'hF3A1, 4'b0000);
        chk("fault_resume_fv", 32'(fv_cnt - fv0), 32'd1);
        chk("fault_resume_digits", 32'(digits), 32'hF3A1);

        fv0 = fv_cnt;
        for (int r = 0; r < 3; r++) begin
            frame4(16'h4321, 4'b0000);
            frame4(16'h5321, 4'b0000);
        end
        chk("alternate_fv", 32'(fv_cnt - fv0), 32'd0);

        drive_an(4'hF, 30);
        chk("pending_publishes", 32'(expq.size()), 32'd0);
        chk("fault_total", 32'(flt_cnt), 32'(exp_flt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
